// File: rtl/vend_dispenser.sv
// vend_dispenser: latches one beverage/change request, strobes the beverage after BEV_DELAY cycles and then pays greedy coins from CHG_DELAY on.
// Defining DISP_HOPPER_STALL_EN adds coin_ready_in, which holds each coin until the hopper takes it.
module vend_dispenser #(
   parameter int BEV_DELAY = 10,
   parameter int CHG_DELAY = 20,
   parameter int COIN_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_in,
   input  logic [1:0]        beverage_in,
   input  logic [COIN_W-1:0] change_in,
`ifdef DISP_HOPPER_STALL_EN
   input  logic              coin_ready_in,
`endif
   output logic              ready_out,
   output logic              bev_valid_out,
   output logic [1:0]        bev_code_out,
   output logic              coin_valid_out,
   output logic [COIN_W-1:0] coin_val_out,
   output logic              done_out,
   output logic              err_out
);

   localparam int CNT_W = $clog2(CHG_DELAY + 1);
   localparam logic [CNT_W-1:0]  BEV_LAST = CNT_W'(BEV_DELAY - 1);
   localparam logic [CNT_W-1:0]  CHG_LAST = CNT_W'(CHG_DELAY - 1);
   localparam logic [COIN_W-1:0] MIN_COIN = COIN_W'(5);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PAY, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [1:0]          r_bev, w_bev_nxt;
   logic [COIN_W-1:0]   r_rem, w_rem_nxt;
   logic                r_ready, w_ready_nxt;
   logic                r_bev_vld, w_bev_vld_nxt;
   logic [1:0]          r_bev_code, w_bev_code_nxt;
   logic                r_coin_vld, w_coin_vld_nxt;
   logic [COIN_W-1:0]   r_coin_val, w_coin_val_nxt;
   logic                r_done, w_done_nxt;
   logic                r_err, w_err_nxt;
   logic [COIN_W-1:0]   w_coin;
   logic                w_pay_more;
   logic                w_coin_ack;

`ifdef DISP_HOPPER_STALL_EN
   assign w_coin_ack = coin_ready_in;
`else
   assign w_coin_ack = 1'b1;
`endif

   // Largest denomination not exceeding the remainder; only used when rem >= 5.
   function automatic logic [COIN_W-1:0] f_greedy(input logic [COIN_W-1:0] rem);
      logic [COIN_W-1:0] d;
      if (rem >= COIN_W'(200))      d = COIN_W'(200);
      else if (rem >= COIN_W'(100)) d = COIN_W'(100);
      else if (rem >= COIN_W'(50))  d = COIN_W'(50);
      else if (rem >= COIN_W'(20))  d = COIN_W'(20);
      else if (rem >= COIN_W'(10))  d = COIN_W'(10);
      else                          d = COIN_W'(5);
      return d;
   endfunction

   assign w_coin     = f_greedy(r_rem);
   assign w_pay_more = (r_rem >= MIN_COIN);

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_bev_nxt      = r_bev;
      w_rem_nxt      = r_rem;
      w_bev_vld_nxt  = 1'b0;
      w_bev_code_nxt = 2'd0;
      w_coin_vld_nxt = 1'b0;
      w_coin_val_nxt = '0;
      w_done_nxt     = 1'b0;
      w_err_nxt      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_in) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = '0;
               w_bev_nxt   = beverage_in;
               w_rem_nxt   = change_in;
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == BEV_LAST && r_bev != 2'd0) begin
               w_bev_vld_nxt  = 1'b1;
               w_bev_code_nxt = r_bev;
            end
            if (r_cnt == CHG_LAST) begin
               if (w_pay_more) begin
                  w_state_nxt    = S_PAY;
                  w_coin_vld_nxt = 1'b1;
                  w_coin_val_nxt = w_coin;
                  w_rem_nxt      = r_rem - w_coin;
               end else begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = (r_rem != '0);
               end
            end
         end
         S_PAY: begin
            // r_rem already excludes the coin on display; hold it until accepted.
            if (!w_coin_ack) begin
               w_coin_vld_nxt = 1'b1;
               w_coin_val_nxt = r_coin_val;
            end else if (w_pay_more) begin
               w_coin_vld_nxt = 1'b1;
               w_coin_val_nxt = w_coin;
               w_rem_nxt      = r_rem - w_coin;
            end else begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
               w_err_nxt   = (r_rem != '0);
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      w_ready_nxt = (w_state_nxt == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bev      <= 2'd0;
         r_rem      <= '0;
         r_ready    <= 1'b1;
         r_bev_vld  <= 1'b0;
         r_bev_code <= 2'd0;
         r_coin_vld <= 1'b0;
         r_coin_val <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bev      <= w_bev_nxt;
         r_rem      <= w_rem_nxt;
         r_ready    <= w_ready_nxt;
         r_bev_vld  <= w_bev_vld_nxt;
         r_bev_code <= w_bev_code_nxt;
         r_coin_vld <= w_coin_vld_nxt;
         r_coin_val <= w_coin_val_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
      end
   end

   assign ready_out      = r_ready;
   assign bev_valid_out  = r_bev_vld;
   assign bev_code_out   = r_bev_code;
   assign coin_valid_out = r_coin_vld;
   assign coin_val_out   = r_coin_val;
   assign done_out       = r_done;
   assign err_out        = r_err;

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: directed and random transactions against a per-cycle trace model.
// Output vector layout {ready, bev_vld, bev_code, coin_vld, coin_val, done, err}.
module tb_vend_dispenser;

   localparam int BEV   = 10;
   localparam int CHG   = 20;
   localparam int DEPTH = 256;

   logic        clk;
   logic        rst;
   logic        req_in;
   logic [1:0]  beverage_in;
   logic [15:0] change_in;
   logic        ready_out, bev_valid_out, coin_valid_out, done_out, err_out;
   logic [1:0]  bev_code_out;
   logic [15:0] coin_val_out;
`ifdef DISP_HOPPER_STALL_EN
   logic        coin_ready_in;
`endif

   int vectors = 0;
   int fails   = 0;

   logic [22:0] exp_q [0:DEPTH-1];
   logic [22:0] obs_q [0:DEPTH-1];
   bit          stall_q [0:DEPTH-1];
   int          denom [6] = '{200, 100, 50, 20, 10, 5};

   vend_dispenser #(.BEV_DELAY(BEV), .CHG_DELAY(CHG), .COIN_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_in         (req_in),
      .beverage_in    (beverage_in),
      .change_in      (change_in),
`ifdef DISP_HOPPER_STALL_EN
      .coin_ready_in  (coin_ready_in),
`endif
      .ready_out      (ready_out),
      .bev_valid_out  (bev_valid_out),
      .bev_code_out   (bev_code_out),
      .coin_valid_out (coin_valid_out),
      .coin_val_out   (coin_val_out),
      .done_out       (done_out),
      .err_out        (err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [22:0] pk(input logic r, input logic bv, input logic [1:0] code,
                                      input logic cv, input logic [15:0] val,
                                      input logic d, input logic e);
      return {r, bv, code, cv, val, d, e};
   endfunction

   function automatic logic [22:0] obs_now();
      return pk(ready_out, bev_valid_out, bev_code_out, coin_valid_out, coin_val_out, done_out, err_out);
   endfunction

   // Reference: coin counts by integer division per denomination, then a cycle timeline.
   task automatic build_exp(input logic [1:0] bev, input int chg, output int len);
      int rem, n, t;
      logic [15:0] coins[$];
      rem = chg;
      foreach (denom[i]) begin
         n   = rem / denom[i];
         rem = rem % denom[i];
         repeat (n) coins.push_back(16'(denom[i]));
      end
      for (int c = 0; c < DEPTH; c++) exp_q[c] = '0;
      if (bev != 2'd0) exp_q[BEV] = pk(1'b0, 1'b1, bev, 1'b0, 16'd0, 1'b0, 1'b0);
      t = CHG;
      foreach (coins[i]) begin
         while (t < DEPTH - 4 && stall_q[t]) begin
            exp_q[t] = pk(1'b0, 1'b0, 2'd0, 1'b1, coins[i], 1'b0, 1'b0);
            t++;
         end
         exp_q[t] = pk(1'b0, 1'b0, 2'd0, 1'b1, coins[i], 1'b0, 1'b0);
         t++;
      end
      exp_q[t]     = pk(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b1, rem != 0);
      exp_q[t + 1] = pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0);
      len = t + 2;
   endtask

   task automatic clear_stall();
      for (int c = 0; c < DEPTH; c++) stall_q[c] = 1'b0;
   endtask

   // Starts at a negedge; issues one request and records len cycles (cycle 0 = accept edge).
   task automatic capture(input logic [1:0] bev, input logic [15:0] chg, input int len,
                          input int pulse_cyc, input bit rnd_req);
      int waited = 0;
`ifdef DISP_HOPPER_STALL_EN
      coin_ready_in = 1'b1;
`endif
      while (ready_out !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (ready_out !== 1'b1) begin
         vectors++;
         fails++;
         $display("FAIL ready_timeout got ready=%b required 1", ready_out);
      end
      req_in      = 1'b1;
      beverage_in = bev;
      change_in   = chg;
      @(posedge clk);
      #1 req_in = 1'b0;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         obs_q[c] = obs_now();
         if (c < len - 1) begin
            req_in      = rnd_req ? 1'($urandom) : (c + 1 == pulse_cyc);
            beverage_in = 2'($urandom);
            change_in   = 16'($urandom);
         end else begin
            req_in = 1'b0;
         end
`ifdef DISP_HOPPER_STALL_EN
         coin_ready_in = !stall_q[c];
`endif
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs_now() !== pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0)) begin
         fails++;
         $display("FAIL reset_hold got %h required %h", obs_now(), pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0));
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (obs_now() !== pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0)) begin
            fails++;
            $display("FAIL reset_idle cyc %0d got %h required %h", c, obs_now(), pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic test_bev_385();
      int len;
      build_exp(2'd2, 385, len);
      capture(2'd2, 16'd385, len, -1, 1'b0);
      for (int c = 0; c < len; c++) begin
         vectors++;
         if (obs_q[c] !== exp_q[c]) begin
            fails++;
            $display("FAIL bev385 cyc %0d got %h required %h", c, obs_q[c], exp_q[c]);
         end
      end
   endtask

   task automatic test_change_7();
      int len;
      build_exp(2'd0, 7, len);
      capture(2'd0, 16'd7, len, -1, 1'b0);
      for (int c = 0; c < len; c++) begin
         vectors++;
         if (obs_q[c] !== exp_q[c]) begin
            fails++;
            $display("FAIL change7 cyc %0d got %h required %h", c, obs_q[c], exp_q[c]);
         end
      end
   endtask

   task automatic test_nothing();
      int len;
      build_exp(2'd0, 0, len);
      capture(2'd0, 16'd0, len, -1, 1'b0);
      for (int c = 0; c < len; c++) begin
         vectors++;
         if (obs_q[c] !== exp_q[c]) begin
            fails++;
            $display("FAIL nothing cyc %0d got %h required %h", c, obs_q[c], exp_q[c]);
         end
      end
   endtask

   task automatic test_busy_40();
      int len;
      build_exp(2'd1, 40, len);
      capture(2'd1, 16'd40, len, 5, 1'b0);
      for (int c = 0; c < len; c++) begin
         vectors++;
         if (obs_q[c] !== exp_q[c]) begin
            fails++;
            $display("FAIL busy40 cyc %0d got %h required %h", c, obs_q[c], exp_q[c]);
         end
      end
   endtask

   task automatic test_reset_mid();
      req_in      = 1'b1;
      beverage_in = 2'd3;
      change_in   = 16'd385;
      @(posedge clk);
      #1 req_in = 1'b0;
      repeat (13) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (obs_now() !== pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0)) begin
         fails++;
         $display("FAIL reset_mid_now got %h required %h", obs_now(), pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0));
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         vectors++;
         if (obs_now() !== pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0)) begin
            fails++;
            $display("FAIL reset_mid_after cyc %0d got %h required %h", c, obs_now(), pk(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic test_random(input int n, input bit rnd_req);
      int len;
      logic [1:0]  bev;
      logic [15:0] chg;
      for (int i = 0; i < n; i++) begin
         bev = 2'($urandom_range(0, 3));
         chg = 16'($urandom_range(0, 1200));
         clear_stall();
`ifdef DISP_HOPPER_STALL_EN
         for (int c = CHG; c < 150; c++) stall_q[c] = ($urandom_range(0, 2) == 0);
`endif
         build_exp(bev, int'(chg), len);
         capture(bev, chg, len, -1, rnd_req);
         for (int c = 0; c < len; c++) begin
            vectors++;
            if (obs_q[c] !== exp_q[c]) begin
               fails++;
               $display("FAIL random txn %0d bev %0d chg %0d cyc %0d got %h required %h",
                        i, bev, chg, c, obs_q[c], exp_q[c]);
            end
         end
      end
      clear_stall();
   endtask

`ifdef DISP_HOPPER_STALL_EN
   task automatic test_hopper_stall();
      int len;
      clear_stall();
      stall_q[20] = 1'b1;
      stall_q[21] = 1'b1;
      stall_q[22] = 1'b1;
      build_exp(2'd0, 30, len);
      capture(2'd0, 16'd30, len, -1, 1'b0);
      for (int c = 0; c < len; c++) begin
         vectors++;
         if (obs_q[c] !== exp_q[c]) begin
            fails++;
            $display("FAIL hopper_stall cyc %0d got %h required %h", c, obs_q[c], exp_q[c]);
         end
      end
      clear_stall();
   endtask
`endif

   initial begin
      rst         = 1'b1;
      req_in      = 1'b0;
      beverage_in = 2'd0;
      change_in   = 16'd0;
`ifdef DISP_HOPPER_STALL_EN
      coin_ready_in = 1'b1;
`endif
      clear_stall();
      test_reset();
      test_bev_385();
      test_change_7();
      test_nothing();
      test_busy_40();
      test_reset_mid();
`ifdef DISP_HOPPER_STALL_EN
      test_hopper_stall();
`endif
      test_random(4, 1'b0);
      test_random(30, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
